// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle/stall/flush/retire counters with run FSM.
// Optional PERF_SAT_EN: counters saturate instead of wrapping.
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clr_i,
  input  logic [1:0]       sel_i,
  input  logic             rd_en_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             halt_o
);

  localparam int LIM_W = $clog2(CYCLE_LIMIT + 1);
  localparam logic [63:0] CMAX = (64'd1 << CNT_W) - 64'd1;
`ifdef PERF_SAT_EN
  localparam logic [63:0] LIM =
    (64'(CYCLE_LIMIT) < CMAX) ? 64'(CYCLE_LIMIT) : CMAX;
`else
  localparam logic [63:0] LIM = 64'(CYCLE_LIMIT);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] rd_mux;

  // run_cnt tracks counted edges independently of cyc_cnt width/wrap
  logic [LIM_W-1:0] run_cnt;
  logic [LIM_W-1:0] run_nxt;
  logic             cnt_en;
  logic             last;

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] v
  );
`ifdef PERF_SAT_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  assign run_nxt = run_cnt + LIM_W'(1);
  assign last    = (64'(run_nxt) == LIM);
  assign cnt_en  = (state == RUN) & start_i & ~clr_i;

  always_comb begin
    state_n = state;
    if (clr_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start_i) state_n = RUN;
        RUN:  if (cnt_en && last) state_n = DONE;
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = cyc_cnt;
    unique case (sel_i)
      2'd0: rd_mux = cyc_cnt;
      2'd1: rd_mux = stall_cnt;
      2'd2: rd_mux = flush_cnt;
      2'd3: rd_mux = ret_cnt;
      default: rd_mux = cyc_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      ret_cnt    <= '0;
      run_cnt    <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      halt_o     <= 1'b0;
    end else begin
      state      <= state_n;
      halt_o     <= (state_n == DONE);
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_mux;
      if (clr_i) begin
        cyc_cnt   <= '0;
        stall_cnt <= '0;
        flush_cnt <= '0;
        ret_cnt   <= '0;
        run_cnt   <= '0;
      end else if (cnt_en) begin
        cyc_cnt <= bump(cyc_cnt);
        run_cnt <= run_nxt;
        // a flush suppresses the stall count
        if (flush_i)      flush_cnt <= bump(flush_cnt);
        else if (stall_i) stall_cnt <= bump(stall_cnt);
        if (retire_i)     ret_cnt   <= bump(ret_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Randomized + directed bench for pipe_perf_monitor against an integer model.
// Runs a default instance and a CNT_W=4 instance on the same stimulus.
module tb_pipe_perf_monitor;

  logic clk = 1'b0;
  logic rst, start, stall, flush, retire, clr, rd_en;
  logic [1:0] sel;
  logic [31:0] rd_a;
  logic [3:0]  rd_b;
  logic va, vb, ha, hb;

  int total = 0;
  int bad = 0;

  int     m_cnt[2][4];
  int     m_st[2];
  longint m_rd[2];
  bit     m_v[2];
  longint m_lim[2];
  int     m_w[2];

  always #5 clk = ~clk;

  pipe_perf_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .clr_i(clr), .sel_i(sel),
    .rd_en_i(rd_en), .rd_data_o(rd_a),
    .rd_valid_o(va), .halt_o(ha)
  );

  pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(64)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .clr_i(clr), .sel_i(sel),
    .rd_en_i(rd_en), .rd_data_o(rd_b),
    .rd_valid_o(vb), .halt_o(hb)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic longint cmax(input int m);
    return (longint'(1) << m_w[m]) - 1;
  endfunction

  function automatic longint disp(input int m, input int v);
`ifdef PERF_SAT_EN
    return (v > cmax(m)) ? cmax(m) : longint'(v);
`else
    return longint'(v) % (cmax(m) + 1);
`endif
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) m_cnt[m][k] = 0;
      m_st[m] = 0;
      m_rd[m] = 0;
      m_v[m]  = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      m_v[m] = rd_en;
      if (rd_en) m_rd[m] = disp(m, m_cnt[m][sel]);
      if (clr) begin
        for (int k = 0; k < 4; k++) m_cnt[m][k] = 0;
        m_st[m] = 0;
      end else if (m_st[m] == 0) begin
        if (start) m_st[m] = 1;
      end else if (m_st[m] == 1 && start) begin
        m_cnt[m][0]++;
        if (flush) m_cnt[m][2]++;
        else if (stall) m_cnt[m][1]++;
        if (retire) m_cnt[m][3]++;
        if (m_cnt[m][0] == m_lim[m]) m_st[m] = 2;
      end
    end
  endtask

  task automatic check_all();
    chk("rdv_a", va, m_v[0]);
    chk("rdd_a", rd_a, m_rd[0]);
    chk("halt_a", ha, m_st[0] == 2);
    chk("rdv_b", vb, m_v[1]);
    chk("rdd_b", rd_b, m_rd[1]);
    chk("halt_b", hb, m_st[1] == 2);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input bit s, input bit st,
                        input bit f, input bit r,
                        input bit c, input bit e,
                        input logic [1:0] sl);
    start = s; stall = st; flush = f; retire = r;
    clr = c; rd_en = e; sel = sl;
  endtask

  task automatic do_clr();
    set_in(0, 0, 0, 0, 1, 0, 0);
    cyc();
  endtask

  initial begin
    int n;
    m_w[0] = 32;
    m_w[1] = 4;
    for (int m = 0; m < 2; m++) begin
`ifdef PERF_SAT_EN
      m_lim[m] = (64 < cmax(m)) ? 64 : cmax(m);
`else
      m_lim[m] = 64;
`endif
    end
    model_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #12;
    check_all();
    @(posedge clk);
    #1 rst = 1'b1;

    // full run, no events
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (70) cyc();
    for (int s = 0; s < 4; s++) begin
      set_in(1, 0, 0, 0, 0, 1, 2'(s));
      cyc();
      chk("run_rd", rd_a, (s == 0) ? 64 : 0);
    end

    // stall/flush overlap
    do_clr();
    set_in(1, 0, 0, 0, 0, 0, 0); cyc();
    set_in(1, 1, 0, 0, 0, 0, 0); cyc();
    set_in(1, 1, 1, 0, 0, 0, 0); cyc();
    set_in(1, 1, 0, 0, 0, 0, 0); cyc();
    set_in(1, 0, 1, 0, 0, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0, 1, 2'd1); cyc();
    chk("stall_cnt", rd_a, 2);
    set_in(1, 0, 0, 0, 0, 1, 2'd2); cyc();
    chk("flush_cnt", rd_a, 2);

    // pause mid-run
    do_clr();
    set_in(1, 0, 0, 0, 0, 0, 0); cyc();
    repeat (10) cyc();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 2'd0);
      cyc();
      chk("pause_cyc", rd_a, 10);
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!ha && n < 100) begin
      cyc();
      n++;
    end
    chk("pause_lat", n, 54);

    // clear and read on same edge
    do_clr();
    set_in(1, 0, 0, 0, 0, 0, 0); cyc();
    set_in(1, 0, 0, 1, 0, 0, 0);
    repeat (7) cyc();
    set_in(1, 0, 0, 1, 1, 1, 2'd3); cyc();
    chk("clr_rd", rd_a, 7);
    chk("clr_rdv", va, 1);
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("clr_rdv_pulse", va, 0);
    chk("clr_halt", ha, 0);
    for (int s = 0; s < 4; s++) begin
      set_in(0, 0, 0, 0, 0, 1, 2'(s));
      cyc();
      chk("clr_zero", rd_a, 0);
    end

    // narrow counters, retire held
    do_clr();
    set_in(1, 0, 0, 0, 0, 0, 0); cyc();
    set_in(1, 0, 0, 1, 0, 0, 0);
    repeat (70) cyc();
    set_in(1, 0, 0, 1, 0, 1, 2'd3); cyc();
`ifdef PERF_SAT_EN
    chk("narrow_ret", rd_b, 15);
`else
    chk("narrow_ret", rd_b, 0);
`endif
    chk("wide_ret", rd_a, 64);

    // async reset mid-run
    do_clr();
    set_in(1, 0, 0, 1, 0, 1, 2'd0); cyc();
    repeat (20) cyc();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_rd", rd_a, 0);
    chk("arst_rdv", va, 0);
    chk("arst_halt", ha, 0);
    check_all();
    #2 rst = 1'b1;
    set_in(0, 1, 1, 1, 0, 0, 0);
    repeat (5) cyc();
    set_in(0, 0, 0, 0, 0, 1, 2'd0); cyc();
    chk("arst_idle", rd_a, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom_range(7) != 0),
             1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(60) == 0),
             1'($urandom), 2'($urandom));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
